decode_stage: RTL



---
 rtl/decode_stage.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes fetched words and buffers them in a DEPTH-entry FIFO for execute.
// Optional M-extension decode is enabled by defining RVECE_MEXT_EN.
module decode_stage #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 2,
   parameter int CTRL_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [31:0]       i_instr,
   input  logic [XLEN-1:0]   i_pc,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [CTRL_W-1:0] o_alu_ctrl,
   output logic [XLEN-1:0]   o_imm,
   output logic [4:0]        o_rs1,
   output logic [4:0]        o_rs2,
   output logic [4:0]        o_rd,
   output logic [XLEN-1:0]   o_pc,
   output logic              o_br_inv,
   output logic              o_illegal,
   output logic [CNT_W-1:0]  o_illegal_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] ALU_EQ   = 5'd10;
   localparam logic [4:0] ALU_GE   = 5'd11;
   localparam logic [4:0] ALU_GEU  = 5'd12;
   localparam logic [4:0] ALU_BUF  = 5'd13;
   localparam logic [4:0] ALU_MUL  = 5'd16;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

`ifdef RVECE_MEXT_EN
   generate
      if (CTRL_W < 5) begin : g_ctrl_w_check
         $error("CTRL_W must be at least 5 when RVECE_MEXT_EN is defined");
      end
   endgenerate
`endif

   typedef struct packed {
      logic [CTRL_W-1:0] alu_ctrl;
      logic [XLEN-1:0]   imm;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [XLEN-1:0]   pc;
      logic              br_inv;
      logic              illegal;
   } entry_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // ---------------- combinational decode ----------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [4:0]  alu_code;
   logic [31:0] imm_sel;
   logic        dec_illegal;
   logic        dec_branch;
   entry_t      dec_entry;

   assign opcode = i_instr[6:0];
   assign funct3 = i_instr[14:12];
   assign funct7 = i_instr[31:25];

   assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign imm_u = {i_instr[31:12], 12'b0};
   assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      alu_code    = ALU_ADD;
      imm_sel     = 32'd0;
      dec_illegal = 1'b0;
      dec_branch  = 1'b0;
      case (opcode)
         OP_R: begin
            case (funct7)
               7'b0000000: begin
                  case (funct3)
                     3'd0:    alu_code = ALU_ADD;
                     3'd1:    alu_code = ALU_SLL;
                     3'd2:    alu_code = ALU_SLT;
                     3'd3:    alu_code = ALU_SLTU;
                     3'd4:    alu_code = ALU_XOR;
                     3'd5:    alu_code = ALU_SRL;
                     3'd6:    alu_code = ALU_OR;
                     default: alu_code = ALU_AND;
                  endcase
               end
               7'b0100000: begin
                  if (funct3 == 3'd0)      alu_code = ALU_SUB;
                  else if (funct3 == 3'd5) alu_code = ALU_SRA;
                  else                     dec_illegal = 1'b1;
               end
`ifdef RVECE_MEXT_EN
               7'b0000001: alu_code = ALU_MUL + {2'b00, funct3};
`endif
               default: dec_illegal = 1'b1;
            endcase
         end
         OP_I: begin
            imm_sel = imm_i;
            case (funct3)
               3'd0: alu_code = ALU_ADD;
               3'd1: begin
                  alu_code    = ALU_SLL;
                  dec_illegal = (funct7 != 7'b0000000);
               end
               3'd2: alu_code = ALU_SLT;
               3'd3: alu_code = ALU_SLTU;
               3'd4: alu_code = ALU_XOR;
               3'd5: begin
                  if (funct7 == 7'b0000000)      alu_code = ALU_SRL;
                  else if (funct7 == 7'b0100000) alu_code = ALU_SRA;
                  else                           dec_illegal = 1'b1;
               end
               3'd6:    alu_code = ALU_OR;
               default: alu_code = ALU_AND;
            endcase
         end
         OP_LOAD, OP_JALR: begin
            alu_code = ALU_ADD;
            imm_sel  = imm_i;
         end
         OP_STORE: begin
            alu_code = ALU_ADD;
            imm_sel  = imm_s;
         end
         OP_AUIPC: begin
            alu_code = ALU_ADD;
            imm_sel  = imm_u;
         end
         OP_LUI: begin
            alu_code = ALU_BUF;
            imm_sel  = imm_u;
         end
         OP_JAL: begin
            alu_code = ALU_BUF;
            imm_sel  = imm_j;
         end
         OP_BRANCH: begin
            imm_sel    = imm_b;
            dec_branch = 1'b1;
            // funct3[2:1] selects compare kind; funct3[0] selects inversion
            case (funct3[2:1])
               2'b00:   alu_code = ALU_EQ;
               2'b10:   alu_code = ALU_GE;
               2'b11:   alu_code = ALU_GEU;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      dec_entry          = '0;
      dec_entry.rs1      = i_instr[19:15];
      dec_entry.rs2      = i_instr[24:20];
      dec_entry.rd       = i_instr[11:7];
      dec_entry.pc       = i_pc;
      dec_entry.illegal  = dec_illegal;
      if (dec_illegal) begin
         dec_entry.alu_ctrl = '1;
         dec_entry.imm      = '0;
         dec_entry.br_inv   = 1'b0;
      end else begin
         dec_entry.alu_ctrl = CTRL_W'(alu_code);
         dec_entry.imm      = sext32(imm_sel);
         dec_entry.br_inv   = dec_branch & funct3[0];
      end
   end

   // ---------------- output FIFO ----------------
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [PTR_W:0]   count_reg, count_next;
   logic [CNT_W-1:0] illegal_cnt_reg, illegal_cnt_next;
   logic             push_en, pop_en;
   entry_t           entry_reg [DEPTH];
   entry_t           head_entry;

   assign o_ready = !i_rst && (count_reg < DEPTH_C);
   assign o_valid = (count_reg != '0);
   assign push_en = i_valid && o_ready && !i_flush;
   assign pop_en  = o_valid && i_ready && !i_flush;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge i_clk) begin
            if (push_en && (tail_reg == PTR_W'(gi))) begin
               entry_reg[gi] <= dec_entry;
            end
         end
      end
   endgenerate

   always_comb begin
      head_next        = head_reg;
      tail_next        = tail_reg;
      count_next       = count_reg;
      illegal_cnt_next = illegal_cnt_reg;
      if (i_flush) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (push_en) tail_next = tail_reg + 1'b1;
         if (pop_en)  head_next = head_reg + 1'b1;
         if (push_en && !pop_en)      count_next = count_reg + 1'b1;
         else if (pop_en && !push_en) count_next = count_reg - 1'b1;
         if (push_en && dec_entry.illegal && (illegal_cnt_reg != '1)) begin
            illegal_cnt_next = illegal_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head_reg        <= '0;
         tail_reg        <= '0;
         count_reg       <= '0;
         illegal_cnt_reg <= '0;
      end else begin
         head_reg        <= head_next;
         tail_reg        <= tail_next;
         count_reg       <= count_next;
         illegal_cnt_reg <= illegal_cnt_next;
      end
   end

   // An empty FIFO presents an all-zero payload
   assign head_entry    = o_valid ? entry_reg[head_reg] : '0;
   assign o_alu_ctrl    = head_entry.alu_ctrl;
   assign o_imm         = head_entry.imm;
   assign o_rs1         = head_entry.rs1;
   assign o_rs2         = head_entry.rs2;
   assign o_rd          = head_entry.rd;
   assign o_pc          = head_entry.pc;
   assign o_br_inv      = head_entry.br_inv;
   assign o_illegal     = head_entry.illegal;
   assign o_illegal_cnt = illegal_cnt_reg;

endmodule
